// File: rtl/instr_fetcher.sv
// Instruction fetch stage: one-outstanding icache requester with a 2-bit BHT
// branch predictor feeding a single-entry output register toward the decoder.
module instr_fetcher #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        is_jump_instr,
  output logic        jump_prediction,
  input  logic        stall_IF,
  input  logic        rob_flush,
  input  logic [31:0] rob_target_pc,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        is_jump_q;
  logic        pred_q;
  logic [1:0]  bht_q [BHT_N];

  logic [31:0] nextPc_d;
  logic        isJump_d;
  logic        predTaken_d;
  logic [31:0] jImm;
  logic [31:0] bImm;
  logic [1:0]  bhtCtr;
  logic        handoff;
  logic        issueReq;
  logic [BHT_IDX_W-1:0] brIdx;
  logic        unusedBrPc;

  assign handoff  = instr_valid_q & ~stall_IF;
  assign issueReq = (state_q == FETCH) & rdy & ~rst & ~rob_flush
                    & (~instr_valid_q | ~stall_IF);
  assign brIdx      = br_pc[BHT_IDX_W+1:2];
  assign unusedBrPc = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

  assign icache_req      = issueReq;
  assign icache_addr     = pc_q;
  assign instr           = instr_q;
  assign instr_pc        = instr_pc_q;
  assign instr_valid     = instr_valid_q;
  assign is_jump_instr   = is_jump_q;
  assign jump_prediction = pred_q;

  // Predecode the returning word against the PC it was fetched from.
  always_comb begin
    jImm   = {{11{icache_data[31]}}, icache_data[31], icache_data[19:12],
              icache_data[20], icache_data[30:21], 1'b0};
    bImm   = {{19{icache_data[31]}}, icache_data[31], icache_data[7],
              icache_data[30:25], icache_data[11:8], 1'b0};
    bhtCtr      = bht_q[pc_q[BHT_IDX_W+1:2]];
    isJump_d    = 1'b0;
    predTaken_d = 1'b0;
    nextPc_d    = pc_q + 32'd4;
    case (icache_data[6:0])
      OP_JAL: begin
        isJump_d    = 1'b1;
        predTaken_d = 1'b1;
        nextPc_d    = pc_q + jImm;
      end
      OP_JALR: isJump_d = 1'b1;
      OP_BRANCH: begin
        isJump_d = 1'b1;
        if (bhtCtr[1]) begin
          predTaken_d = 1'b1;
          nextPc_d    = pc_q + bImm;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      is_jump_q     <= 1'b0;
      pred_q        <= 1'b0;
    end else if (rdy) begin
      if (handoff) instr_valid_q <= 1'b0;
      if (rob_flush) begin
        // A flush while a response is still owed must swallow that response.
        pc_q          <= rob_target_pc;
        instr_valid_q <= 1'b0;
        if (state_q != FETCH && !icache_valid) state_q <= DISCARD;
        else                                   state_q <= FETCH;
      end else begin
        case (state_q)
          FETCH: if (issueReq) state_q <= WAIT;
          WAIT: if (icache_valid) begin
            instr_q       <= icache_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            is_jump_q     <= isJump_d;
            pred_q        <= predTaken_d;
            pc_q          <= nextPc_d;
            state_q       <= FETCH;
          end
          DISCARD: if (icache_valid) state_q <= FETCH;
          default: state_q <= FETCH;
        endcase
      end
    end
  end

  // Saturating counters; same-cycle lookups see the value before this update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy && br_update) begin
      if (br_taken) begin
        if (bht_q[brIdx] != 2'b11) bht_q[brIdx] <= bht_q[brIdx] + 2'b01;
      end else begin
        if (bht_q[brIdx] != 2'b00) bht_q[brIdx] <= bht_q[brIdx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: a small icache responder model plus logs of
// issued requests and decoder handoffs, compared against hand-computed values.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, icache_valid, stall_IF, rob_flush, br_update, br_taken;
  logic [31:0] icache_data, rob_target_pc, br_pc;
  logic        icache_req, instr_valid, is_jump_instr, jump_prediction;
  logic [31:0] icache_addr, instr, instr_pc;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] JAL16  = 32'h0100006F;
  localparam logic [31:0] BEQM8  = 32'hFE000CE3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        isJump;
    logic        pred;
  } hand_t;

  logic [31:0] reqLog[$];
  hand_t       handLog[$];
  logic [31:0] mem [logic [31:0]];
  int          lat = 1;
  int          pendCnt = 0;
  logic [31:0] pendAddr = 32'h0;
  int          checkCount = 0;
  int          errorCount = 0;

  instr_fetcher #(.RESET_PC(32'h0), .BHT_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_data(icache_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .is_jump_instr(is_jump_instr), .jump_prediction(jump_prediction),
    .stall_IF(stall_IF), .rob_flush(rob_flush), .rob_target_pc(rob_target_pc),
    .br_update(br_update), .br_pc(br_pc), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  function automatic logic [31:0] getReq(input int i);
    if (i < reqLog.size()) return reqLog[i];
    return 32'hDEADBEEF;
  endfunction

  function automatic hand_t getHand(input int i);
    hand_t h;
    h = '{pc: 32'hDEADBEEF, word: 32'hDEADBEEF, isJump: 1'b1, pred: 1'b1};
    if (i < handLog.size()) h = handLog[i];
    return h;
  endfunction

  // One clock: observe what the coming edge will do, then advance the icache model.
  task automatic applyStimulus();
    logic  rdyAtEdge, rstAtEdge;
    hand_t h;
    #1;
    rdyAtEdge = rdy;
    rstAtEdge = rst;
    if (!rst && rdy) begin
      if (icache_req) begin
        reqLog.push_back(icache_addr);
        pendAddr = icache_addr;
        pendCnt  = lat;
      end
      if (instr_valid && !stall_IF) begin
        h.pc = instr_pc; h.word = instr; h.isJump = is_jump_instr; h.pred = jump_prediction;
        handLog.push_back(h);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (rstAtEdge) begin
      pendCnt = 0;
      icache_valid = 1'b0;
    end else begin
      if (icache_valid && rdyAtEdge) icache_valid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          icache_valid = 1'b1;
          icache_data  = memRead(pendAddr);
        end
      end
    end
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1; rdy = 1'b1; stall_IF = 1'b0; rob_flush = 1'b0; br_update = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput({tag, " rst instr_valid"}, instr_valid, 0);
    checkOutput({tag, " rst instr"}, instr, 0);
    checkOutput({tag, " rst instr_pc"}, instr_pc, 0);
    checkOutput({tag, " rst is_jump"}, is_jump_instr, 0);
    checkOutput({tag, " rst pred"}, jump_prediction, 0);
    checkOutput({tag, " rst icache_req"}, icache_req, 0);
    rst = 1'b0;
    reqLog.delete();
    handLog.delete();
  endtask

  task automatic flushTo(input logic [31:0] target);
    rob_flush = 1'b1;
    rob_target_pc = target;
    applyStimulus();
    rob_flush = 1'b0;
  endtask

  task automatic runUntilReqs(input int n, input string tag);
    int cyc = 0;
    while (reqLog.size() < n && cyc < 200) begin applyStimulus(); cyc++; end
    checkOutput({tag, " req count"}, reqLog.size(), n);
  endtask

  task automatic runUntilHands(input int n, input string tag);
    int cyc = 0;
    while (handLog.size() < n && cyc < 200) begin applyStimulus(); cyc++; end
    checkOutput({tag, " handoff count"}, handLog.size(), n);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; icache_valid = 1'b0; icache_data = 32'h0;
    stall_IF = 1'b0; rob_flush = 1'b0; rob_target_pc = 32'h0;
    br_update = 1'b0; br_pc = 32'h0; br_taken = 1'b0;
    @(negedge clk);

    // Straight-line NOPs
    applyReset("A");
    runUntilReqs(3, "A");
    runUntilHands(3, "A");
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("A req%0d", i), getReq(i), 32'(i * 4));
      checkOutput($sformatf("A hand%0d pc", i), getHand(i).pc, 32'(i * 4));
      checkOutput($sformatf("A hand%0d jump", i), getHand(i).isJump, 0);
    end

    // JAL +16 at 0x8
    mem[32'h8] = JAL16;
    applyReset("B");
    runUntilReqs(4, "B");
    runUntilHands(3, "B");
    checkOutput("B jal word", getHand(2).word, JAL16);
    checkOutput("B jal jump", getHand(2).isJump, 1);
    checkOutput("B jal pred", getHand(2).pred, 1);
    checkOutput("B jal target", getReq(3), 32'h18);
    mem.delete(32'h8);

    // Backward branch at 0x20: weakly not-taken, then trained taken
    mem[32'h20] = BEQM8;
    applyReset("C");
    flushTo(32'h20);
    runUntilReqs(2, "C1");
    runUntilHands(1, "C1");
    checkOutput("C1 first addr", getReq(0), 32'h20);
    checkOutput("C1 br jump", getHand(0).isJump, 1);
    checkOutput("C1 br pred", getHand(0).pred, 0);
    checkOutput("C1 next addr", getReq(1), 32'h24);
    br_update = 1'b1; br_pc = 32'h20; br_taken = 1'b1;
    applyStimulus();
    applyStimulus();
    br_update = 1'b0;
    flushTo(32'h20);
    reqLog.delete();
    handLog.delete();
    runUntilReqs(2, "C2");
    runUntilHands(1, "C2");
    checkOutput("C2 refetch addr", getReq(0), 32'h20);
    checkOutput("C2 br pred", getHand(0).pred, 1);
    checkOutput("C2 next addr", getReq(1), 32'h18);

    // Decoder stall holds the output register and blocks new requests
    applyReset("D");
    stall_IF = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) applyStimulus();
    checkOutput("D valid", instr_valid, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("D stall%0d pc", i), instr_pc, 32'h0);
      checkOutput($sformatf("D stall%0d instr", i), instr, NOP);
      checkOutput($sformatf("D stall%0d req", i), icache_req, 0);
    end
    checkOutput("D reqs during stall", reqLog.size(), 1);
    stall_IF = 1'b0;
    applyStimulus();
    checkOutput("D reqs after release", reqLog.size(), 2);
    checkOutput("D next addr", getReq(1), 32'h4);
    checkOutput("D handoff pc", getHand(0).pc, 32'h0);

    // Flush while waiting; the late response must be dropped
    lat = 2;
    applyReset("E");
    applyStimulus();
    flushTo(32'h100);
    checkOutput("E valid after flush", instr_valid, 0);
    applyStimulus();
    checkOutput("E valid after drop", instr_valid, 0);
    runUntilReqs(2, "E");
    checkOutput("E redirect addr", getReq(1), 32'h100);
    runUntilHands(1, "E");
    checkOutput("E first handoff pc", getHand(0).pc, 32'h100);

    // rdy low mid-WAIT freezes everything, BHT included
    applyReset("F");
    applyStimulus();
    rdy = 1'b0;
    br_update = 1'b1; br_pc = 32'h20; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("F frozen%0d req", i), icache_req, 0);
      checkOutput($sformatf("F frozen%0d valid", i), instr_valid, 0);
    end
    rdy = 1'b1;
    br_update = 1'b0;
    applyStimulus();
    checkOutput("F resume valid", instr_valid, 1);
    checkOutput("F resume pc", instr_pc, 32'h0);
    checkOutput("F resume instr", instr, NOP);
    runUntilReqs(2, "F");
    checkOutput("F next addr", getReq(1), 32'h4);
    flushTo(32'h20);
    reqLog.delete();
    handLog.delete();
    runUntilHands(1, "F");
    checkOutput("F br pc", getHand(0).pc, 32'h20);
    checkOutput("F br pred untrained", getHand(0).pred, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
